// File: rtl/gpio_readback_if.sv
// Bus bundle between the host GPIO words, the readback register bank and the
// gpio_readback_tx responder. The master side is the host plus bank; the slave side is the responder.
interface gpio_readback_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic [31:0]       gpio_in;
  logic [31:0]       gpio_out;
  logic              reg_rd_en;
  logic [ADDR_W-1:0] reg_rd_addr;
  logic [DATA_W-1:0] reg_rd_data;
  logic              reg_rd_valid;
  logic              busy;

  modport master (
    output gpio_in, reg_rd_data, reg_rd_valid,
    input  gpio_out, reg_rd_en, reg_rd_addr, busy
  );

  modport slave (
    input  gpio_in, reg_rd_data, reg_rd_valid,
    output gpio_out, reg_rd_en, reg_rd_addr, busy
  );
endinterface

// File: rtl/gpio_readback_tx.sv
// Host register-read responder: synchronizes a GPIO read strobe, fetches one
// byte from the register bank and returns it on gpio_out with an ack toggle.
module gpio_readback_tx #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 8,
  parameter int RD_CLK_BIT     = 25,
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic           clk,
  input logic           rst,
  gpio_readback_if.slave bus
);

  localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [7:0]  TMO_LAST    = 8'(TIMEOUT_CYCLES - 1);
  // Strobe bit of the synchronizer resets high so a strobe held through reset never looks like an edge.
  localparam logic [31:0] SYNC_RST    = 32'h0000_0001 << RD_CLK_BIT;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_REQ    = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  state_t            state_r;
  state_t            state_next_s;
  logic [31:0]       sync1_r;
  logic [31:0]       sync2_r;
  logic              strobe_prev_r;
  logic              req_s;
  logic [3:0]        settle_cnt_r;
  logic [7:0]        tmo_cnt_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] data_r;
  logic              err_r;
  logic              ovr_r;
  logic [31:0]       gpio_out_r;
  logic              rd_en_r;
  logic              busy_r;

  logic settle_clr_s, settle_inc_s, addr_cap_s;
  logic tmo_clr_s, tmo_inc_s, data_ok_s, data_tmo_s, resp_s;

  assign req_s = sync2_r[RD_CLK_BIT] & ~strobe_prev_r;

  // Two-flop synchronizer for the host word plus strobe edge history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r       <= SYNC_RST;
      sync2_r       <= SYNC_RST;
      strobe_prev_r <= 1'b1;
    end else begin
      sync1_r       <= bus.gpio_in;
      sync2_r       <= sync1_r;
      strobe_prev_r <= sync2_r[RD_CLK_BIT];
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state and datapath controls
  always_comb begin
    state_next_s = state_r;
    settle_clr_s = 1'b0;
    settle_inc_s = 1'b0;
    addr_cap_s   = 1'b0;
    tmo_clr_s    = 1'b0;
    tmo_inc_s    = 1'b0;
    data_ok_s    = 1'b0;
    data_tmo_s   = 1'b0;
    resp_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_s) begin
          settle_clr_s = 1'b1;
          state_next_s = ST_SETTLE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt_r == SETTLE_LAST) begin
          addr_cap_s   = 1'b1;
          state_next_s = ST_REQ;
        end else begin
          settle_inc_s = 1'b1;
        end
      end
      ST_REQ: begin
        tmo_clr_s    = 1'b1;
        state_next_s = ST_WAIT;
      end
      ST_WAIT: begin
        // A valid on the final timeout cycle still counts as a good read.
        if (bus.reg_rd_valid) begin
          data_ok_s    = 1'b1;
          state_next_s = ST_RESP;
        end else if (tmo_cnt_r == TMO_LAST) begin
          data_tmo_s   = 1'b1;
          state_next_s = ST_RESP;
        end else begin
          tmo_inc_s = 1'b1;
        end
      end
      ST_RESP: begin
        resp_s       = 1'b1;
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Settle and timeout counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle_cnt_r <= 4'd0;
      tmo_cnt_r    <= 8'd0;
    end else begin
      if (settle_clr_s) begin
        settle_cnt_r <= 4'd0;
      end else if (settle_inc_s) begin
        settle_cnt_r <= settle_cnt_r + 4'd1;
      end
      if (tmo_clr_s) begin
        tmo_cnt_r <= 8'd0;
      end else if (tmo_inc_s) begin
        tmo_cnt_r <= tmo_cnt_r + 8'd1;
      end
    end
  end

  // Address/data capture, sticky overrun and the registered response word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_r     <= '0;
      data_r     <= '0;
      err_r      <= 1'b0;
      ovr_r      <= 1'b0;
      gpio_out_r <= 32'h0000_0000;
      rd_en_r    <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      rd_en_r <= (state_next_s == ST_REQ);
      busy_r  <= (state_next_s != ST_IDLE);
      if (addr_cap_s) begin
        addr_r <= sync2_r[ADDR_W-1:0];
      end
      if (data_ok_s) begin
        data_r <= bus.reg_rd_data;
        err_r  <= 1'b0;
      end else if (data_tmo_s) begin
        data_r <= '0;
        err_r  <= 1'b1;
      end
      // Accepted request clears the flag; an edge arriving while busy is dropped and remembered.
      if (settle_clr_s) begin
        ovr_r <= 1'b0;
      end else if (req_s && (state_r != ST_IDLE)) begin
        ovr_r <= 1'b1;
      end
      if (resp_s) begin
        gpio_out_r <= {addr_r, 5'b00000, ovr_r, err_r, ~gpio_out_r[8], data_r};
      end
    end
  end

  assign bus.gpio_out    = gpio_out_r;
  assign bus.reg_rd_en   = rd_en_r;
  assign bus.reg_rd_addr = addr_r;
  assign bus.busy        = busy_r;

endmodule

// File: doc/gpio_readback_tx.md
# gpio_readback_tx

Responder for host register reads over the GPIO bus. The host places a 16-bit register address on the input GPIO word and raises a dedicated read strobe bit. This block synchronizes the request, fetches the byte from the readback register bank, and returns it on the output GPIO word with an acknowledge toggle. It sits beside the GPIO write decoder at the PS/PL boundary and uses the same address field, 8-bit data width and request-strobe style.

## Interface
- `ADDR_W`, 16, register address width (`gpio_in[15:0]`)
- `DATA_W`, 8, readback data width
- `RD_CLK_BIT`, 25, `gpio_in` bit used as the read request strobe (bit 24 remains the write strobe)
- `SETTLE_CYCLES`, 2, cycles waited after the strobe edge before capturing the address (1..15)
- `TIMEOUT_CYCLES`, 64, maximum cycles to wait for `reg_rd_valid` (2..255)

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `gpio_in`  in  32  host-driven word, asynchronous to `clk`; `[15:0]` address, `[RD_CLK_BIT]` read strobe
- `gpio_out`  out  32  response word: `[7:0]` data, `[8]` ack toggle, `[9]` error, `[10]` overrun, `[31:16]` echoed address
- `reg_rd_en`  out  1  one-cycle read request to the register bank
- `reg_rd_addr`  out  16  address for `reg_rd_en`, held until the response is issued
- `reg_rd_data`  in  8  read data, qualified by `reg_rd_valid`
- `reg_rd_valid`  in  1  read data valid
- `busy`  out  1  high in every state except IDLE

## Operation
- `gpio_in` passes through a 2-flop synchronizer (all 32 bits). The previous-strobe register resets to 1, so a strobe already high at reset release never triggers.
- A request is a 0→1 transition of synchronized `gpio_in[RD_CLK_BIT]`. Falling edges are ignored.
- **IDLE**: on a request, clear the settle counter and go to SETTLE.
- **SETTLE**: count `SETTLE_CYCLES`. On the last cycle, capture synchronized `gpio_in[15:0]` into `reg_rd_addr` and go to REQ.
- **REQ**: assert `reg_rd_en` for exactly one cycle, clear the timeout counter, go to WAIT.
- **WAIT**:
  - If `reg_rd_valid`=1: latch `reg_rd_data`, clear error, go to RESP.
  - Else if the counter reaches `TIMEOUT_CYCLES`-1: set data = 0x00, set error = 1, go to RESP.
  - Otherwise increment the counter.
- **RESP**: in one cycle, write data, error, overrun and the address echo into `gpio_out`, toggle `gpio_out[8]`, go to IDLE.
- `reg_rd_valid` is ignored outside WAIT. `reg_rd_data` is sampled only when valid=1 in WAIT.
- A request edge seen while not in IDLE is dropped and sets a sticky internal overrun flag. The flag is copied to `gpio_out[10]` at the next RESP and cleared when the next accepted request enters SETTLE.
- Host protocol: wait for bit 8 to change, then read `[7:0]`, `[9]` and `[10]`. `gpio_out` fields change only in RESP, so all fields of a response are coherent.

## Timing
- Reset state: `gpio_out` = 0, `reg_rd_en` = 0, `reg_rd_addr` = 0, `busy` = 0, state IDLE, counters 0, overrun flag 0.
- Let E be the cycle in which the second synchronizer stage first shows the strobe high:
  - SETTLE starts at E+1.
  - Address is captured on cycle E+`SETTLE_CYCLES`.
  - `reg_rd_en` is high on cycle E+`SETTLE_CYCLES`+1.
- The earliest accepted valid is the cycle after `reg_rd_en`. The `gpio_out` update is visible the cycle after RESP.
- Minimum latency from raw `gpio_in` strobe to ack toggle, with valid returned the cycle after `reg_rd_en`: `SETTLE_CYCLES`+6 cycles.
- Timeout response: ack toggles `TIMEOUT_CYCLES`+2 cycles after `reg_rd_en`.
- Valid on the timeout-expiry cycle: valid wins, no error.
- `rst` mid-transaction: immediate return to the reset state. `gpio_out[8]` returns to 0, which the host must treat as a reset, not an ack.

## Test plan
- Read 0x0014 with the bank returning 0x5A one cycle after `reg_rd_en`, `SETTLE_CYCLES`=2 → `reg_rd_en` pulses once with addr 0x0014; `gpio_out` = {0x0014, 5'b0, ovr 0, err 0, ack 1, 0x5A}; ack toggles 8 cycles after the strobe.
- Two sequential reads, 0x0006→0x11 then 0x0007→0x22 → ack goes 1 then 0, data 0x11 then 0x22, echoes 0x0006 then 0x0007.
- Bank never asserts valid, `TIMEOUT_CYCLES`=64 → ack toggles 66 cycles after `reg_rd_en`; data 0x00, err 1, `busy` low afterwards.
- Second strobe edge during WAIT → single `reg_rd_en` only; first response has ovr 1; the next clean read has ovr 0.
- Address changed in the same cycle as the strobe edge (0x0008→0x0009) → `reg_rd_addr` = 0x0009; strobe held high through reset release → no request issued.
- `rst` pulsed during WAIT → all outputs 0 asynchronously; a late `reg_rd_valid` is ignored; the next read completes normally.
